// File: rtl/strg_mult_seq_if.sv
// Handshake bundle between the writeback/sequencing logic and the
// load/store multiple and string sequencer.
interface strg_mult_seq_if;
  logic       seqStart;
  logic       seqMultiple;
  logic [0:6] seqByteCnt;
  logic [0:4] seqRT;
  logic       seqAdvance;
  logic       seqFlush;
  logic       seqBusy;
  logic [0:2] strgSt;
  logic [6:7] byteCount;
  logic       cntGtEq4;
  logic       strgEnd;
  logic [0:4] seqRA;
  logic [0:7] seqEaOff;
  logic       seqZeroDone;

  modport master (
    output seqStart, seqMultiple, seqByteCnt, seqRT, seqAdvance, seqFlush,
    input  seqBusy, strgSt, byteCount, cntGtEq4, strgEnd, seqRA, seqEaOff, seqZeroDone
  );

  modport slave (
    input  seqStart, seqMultiple, seqByteCnt, seqRT, seqAdvance, seqFlush,
    output seqBusy, strgSt, byteCount, cntGtEq4, strgEnd, seqRA, seqEaOff, seqZeroDone
  );
endinterface

// File: rtl/strg_mult_seq.sv
// Beat sequencer for load/store multiple and string operations: walks the
// register number and EA offset one word per consumed beat.
module strg_mult_seq (
  input  logic           CB,
  input  logic           reset,
  strg_mult_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    MID   = 2'd2
  } seqState_t;

  seqState_t  state;
  seqState_t  stateNxt;
  logic [0:7] rem;
  logic [0:7] remNxt;
  logic [0:4] ra;
  logic [0:4] raNxt;
  logic [0:7] eaOff;
  logic [0:7] eaOffNxt;
  logic       zeroDone;
  logic       zeroDoneNxt;
  logic [0:7] startCnt;
  logic       busy;
  logic       lastBeat;

  // A multiple op always runs up to r31, so its byte count is 4*(32-RT) and
  // reaches 128 for RT=0 -- the reason the counter is 8 bits wide.
  function automatic logic [0:7] initialCount(input logic       multiple,
                                              input logic [0:6] byteCnt,
                                              input logic [0:4] rt);
    if (multiple) begin
      initialCount = 8'd128 - {1'b0, rt, 2'b00};
    end else begin
      initialCount = {1'b0, byteCnt};
    end
  endfunction

  assign startCnt = initialCount(bus.seqMultiple, bus.seqByteCnt, bus.seqRT);
  assign busy     = (state != IDLE);
  assign lastBeat = (rem <= 8'd4);

  // Next-state and counter update; flush outranks advance and start.
  always_comb begin
    stateNxt    = state;
    remNxt      = rem;
    raNxt       = ra;
    eaOffNxt    = eaOff;
    zeroDoneNxt = 1'b0;
    case (state)
      IDLE: begin
        if (bus.seqFlush) begin
          remNxt = 8'd0;
        end else if (bus.seqStart) begin
          remNxt   = startCnt;
          raNxt    = bus.seqRT;
          eaOffNxt = 8'd0;
          if (startCnt != 8'd0) begin
            stateNxt = FIRST;
          end else begin
            zeroDoneNxt = 1'b1;
          end
        end else begin
          stateNxt = IDLE;
        end
      end
      FIRST, MID: begin
        if (bus.seqFlush) begin
          stateNxt = IDLE;
          remNxt   = 8'd0;
        end else if (bus.seqAdvance) begin
          if (lastBeat) begin
            stateNxt = IDLE;
            remNxt   = 8'd0;
          end else begin
            stateNxt = MID;
            remNxt   = rem - 8'd4;
            raNxt    = ra + 5'd1;
            eaOffNxt = eaOff + 8'd4;
          end
        end else begin
          stateNxt = state;
        end
      end
      default: begin
        stateNxt = IDLE;
        remNxt   = 8'd0;
      end
    endcase
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge CB) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= 8'd0;
      ra       <= 5'd0;
      eaOff    <= 8'd0;
      zeroDone <= 1'b0;
    end else begin
      state    <= stateNxt;
      rem      <= remNxt;
      ra       <= raNxt;
      eaOff    <= eaOffNxt;
      zeroDone <= zeroDoneNxt;
    end
  end

  assign bus.seqBusy     = busy;
  assign bus.strgEnd     = busy & lastBeat;
  assign bus.cntGtEq4    = busy & (rem >= 8'd4);
  assign bus.byteCount   = (busy && lastBeat && (rem < 8'd4)) ? rem[6:7] : 2'b00;
  assign bus.strgSt      = {busy, (state == FIRST), busy & lastBeat};
  assign bus.seqRA       = ra;
  assign bus.seqEaOff    = eaOff;
  assign bus.seqZeroDone = zeroDone;

endmodule

// File: doc/strg_mult_seq.md
STRG_MULT_SEQ -- requirements
Module: p405s_strgMultSeq

Interface
REQ-001 SHALL have port CB  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset, sampled on CB rising edge.
REQ-003 SHALL have port seqStart  in  1  start request for a load/store multiple or string op.
REQ-004 SHALL have port seqMultiple  in  1  1 = multiple (lmw/stmw), 0 = string (lsw*/stsw*); sampled with seqStart.
REQ-005 SHALL have port seqByteCnt  in  [0:6]  string byte count, 0..127; ignored for multiple.
REQ-006 SHALL have port seqRT  in  [0:4]  first target/source register.
REQ-007 SHALL have port seqAdvance  in  1  current beat consumed by WB stage (wbE1 & wbE2 equivalent).
REQ-008 SHALL have port seqFlush  in  1  abort sequence (wbClearOrFlush equivalent).
REQ-009 SHALL have port seqBusy  out  1  sequence active.
REQ-010 SHALL have port strgSt  out  [0:2]  [0]=busy, [1]=first beat, [2]=last beat.
REQ-011 SHALL have port byteCount  out  [6:7]  remaining mod 4 on last beat, else 2'b00.
REQ-012 SHALL have port cntGtEq4  out  1  remaining bytes >= 4.
REQ-013 SHALL have port strgEnd  out  1  current beat is final beat.
REQ-014 SHALL have port seqRA  out  [0:4]  register for current beat.
REQ-015 SHALL have port seqEaOff  out  [0:7]  byte offset of current beat from start EA.
REQ-016 SHALL have port seqZeroDone  out  1  one-cycle pulse: string start with count 0 completed.

Function
REQ-017 SHALL implement states IDLE, FIRST, MID; strgSt[0] = (state != IDLE), strgSt[1] = (state == FIRST), strgSt[2] = strgEnd.
REQ-018 SHALL hold an 8-bit remaining-byte counter rem; 8 bits because the multiple count reaches 128.
REQ-019 In IDLE, seqStart & ~seqFlush at cycle N SHALL load rem = 4*(32 - seqRT) if seqMultiple, else {1'b0, seqByteCnt}; it SHALL also load seqRA = seqRT and seqEaOff = 0.
REQ-020 If the loaded rem is nonzero, the block SHALL enter FIRST at N+1; if rem = 0, it SHALL stay IDLE and pulse seqZeroDone at N+1.
REQ-021 In FIRST/MID without seqAdvance, all outputs and state SHALL hold (stall).
REQ-022 In FIRST/MID with seqAdvance and rem > 4, the block SHALL set rem -= 4, seqRA += 1 (mod 32 wrap), seqEaOff += 4, and move to MID.
REQ-023 In FIRST/MID with seqAdvance and rem <= 4 (last beat), the block SHALL return to IDLE next cycle.
REQ-024 Combinational outputs: strgEnd = busy & (rem <= 4); cntGtEq4 = busy & (rem >= 4); byteCount = rem[6:7] when strgEnd & rem < 4, else 2'b00.
REQ-025 seqFlush SHALL have priority over seqAdvance and seqStart: next state IDLE, rem = 0; seqZeroDone SHALL be suppressed.
REQ-026 seqStart while busy SHALL be ignored, with no effect on state or counters.
REQ-027 seqStart in the same cycle as the last-beat seqAdvance SHALL be ignored; a new start is accepted only from IDLE.
REQ-028 A multiple op SHALL never wrap seqRA, since it ends at r31; a string op SHALL wrap r31 -> r0.
REQ-029 When IDLE, the outputs strgSt, strgEnd, cntGtEq4, byteCount SHALL be 0; seqRA and seqEaOff SHALL hold their last values.

Reset
REQ-030 reset SHALL dominate all inputs: state IDLE, rem 0, seqRA 0, seqEaOff 0, seqZeroDone 0, so every output is 0 on the cycle after reset is sampled.
REQ-031 reset asserted mid-sequence SHALL abort it with no further beats; the first seqStart after reset deasserts SHALL be accepted normally.

Verification
REQ-032 The bench SHALL cover lmw: seqMultiple=1, seqRT=29, seqAdvance held high.
- Required: 3 beats with seqRA 29,30,31 and seqEaOff 0,4,8.
- strgSt 110, 100, 101; strgEnd only on beat 3; byteCount 00 throughout.
- IDLE on the following cycle.
REQ-033 The bench SHALL cover string wrap: seqMultiple=0, seqByteCnt=6, seqRT=31.
- Beat 1: seqRA 31, cntGtEq4=1.
- Beat 2: seqRA 0, seqEaOff 4, strgEnd=1, cntGtEq4=0, byteCount=2'b10.
REQ-034 The bench SHALL cover zero count: string start with seqByteCnt=0 -> seqZeroDone=1 for exactly one cycle, seqBusy never set.
REQ-035 The bench SHALL cover stall: seqByteCnt=8 with seqAdvance low for 3 cycles after FIRST -> outputs hold at FIRST/seqRA=RT for those cycles, then 2 beats complete normally.
REQ-036 The bench SHALL cover flush: seqFlush together with seqAdvance on beat 2 of a 5-beat multiple -> IDLE next cycle, no further strgEnd; a seqStart on the same cycle is ignored.
REQ-037 The bench SHALL cover reset mid-operation: reset during MID -> all outputs 0 next cycle; a subsequent seqStart begins at FIRST with the new seqRT.
